// File: rtl/ipl_pkg.sv
// Shared types and constants for the interrupt priority / acknowledge path.
// Also used by the Paula interrupt logic.
package ipl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef logic [2:0] lvl_t;

    localparam logic [7:0]  VEC_SPURIOUS   = 8'h18;
    // An acknowledge cycle puts all ones on A[23:4]
    localparam logic [19:0] IACK_ADDR_MASK = 20'hFFFFF;

    function automatic logic [7:1] lvl_onehot(input lvl_t lvl);
        logic [7:0] oh;
        oh = 8'b1 << lvl;
        return oh[7:1];
    endfunction

endpackage

// File: rtl/ipl_prio_enc.sv
// Combinational 7-to-3 priority encoder: the highest set pending bit wins,
// and 0 means nothing is pending.
module ipl_prio_enc
    import ipl_pkg::*;
(
    input  logic [7:1] pending,
    output lvl_t       lvl_enc
);

    always_comb begin
        lvl_enc = 3'd0;
        for (int i = 1; i <= 7; i++) begin
            if (pending[i]) begin
                lvl_enc = lvl_t'(i);
            end
        end
    end

endmodule

// File: rtl/ipl_iack_responder.sv
// Merges level requests into the 68000 _IPL encoding and answers CPU
// interrupt-acknowledge cycles with an autovector.
//
// state | meaning
// IDLE  | _ipl tracks the pending level; waiting for an IACK hit
// RESP  | vpa/vector driven; waiting for _cpu_as to rise or the timeout
// WAIT  | timed out; outputs idle until _cpu_as rises (no re-hit)
module ipl_iack_responder
    import ipl_pkg::*;
#(
    parameter int         TIMEOUT  = 64,
    parameter logic [7:0] VEC_BASE = VEC_SPURIOUS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:1]  int_req,
    input  logic [23:1] cpu_address,
    input  logic        _cpu_as,
    input  logic        cpu_rd,
    output logic [2:0]  _ipl,
    output logic        vpa,
    output logic [15:0] data_out,
    output logic [7:1]  int_ack,
    output logic        iack_err
);

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [7:1]         req_q, req_d;
    logic               req7_prev_q, req7_prev_d;
    logic               nmi_pend_q, nmi_pend_d;
    logic [2:0]         ipl_q, ipl_d;
    lvl_t               ack_lvl_q, ack_lvl_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:1]         int_ack_q, int_ack_d;
    logic               iack_err_q, iack_err_d;

    logic               nmi_rise;
    logic [7:1]         pending;
    logic [7:0]         pending8;
    lvl_t               lvl_enc;
    logic               iack_hit;
    logic [7:0]         vector;

    // A fresh NMI edge is visible in the same cycle it is latched, so level 7
    // reaches _ipl with the same two-clock latency as the level requests.
    assign nmi_rise = req_q[7] & ~req7_prev_q;
    assign pending  = {nmi_pend_q | nmi_rise, req_q[6:1]};
    assign pending8 = {pending, 1'b0};

    ipl_prio_enc u_prio_enc (
        .pending (pending),
        .lvl_enc (lvl_enc)
    );

    assign iack_hit = ((cpu_address[23:4] & IACK_ADDR_MASK) == IACK_ADDR_MASK)
                      & ~_cpu_as & cpu_rd & (cpu_address[3:1] != 3'd0);

    always_comb begin
        state_d     = state_q;
        req_d       = int_req;
        req7_prev_d = req_q[7];
        ack_lvl_d   = ack_lvl_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        int_ack_d   = 7'd0;
        iack_err_d  = 1'b0;

        // Set wins over the acknowledge clear
        if (nmi_rise) begin
            nmi_pend_d = 1'b1;
        end else if (int_ack_q[7]) begin
            nmi_pend_d = 1'b0;
        end else begin
            nmi_pend_d = nmi_pend_q;
        end

        ipl_d = (state_q == IDLE) ? ~lvl_enc : ipl_q;

        case (state_q)
            IDLE: begin
                if (iack_hit) begin
                    ack_lvl_d = cpu_address[3:1];
                    valid_d   = pending8[cpu_address[3:1]];
                    cnt_d     = CNT_LOAD;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (_cpu_as) begin
                    if (valid_q) begin
                        int_ack_d = lvl_onehot(ack_lvl_q);
                    end else begin
                        iack_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    iack_err_d = 1'b1;
                    state_d    = WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT: begin
                if (_cpu_as) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_q       <= 7'd0;
            req7_prev_q <= 1'b0;
            nmi_pend_q  <= 1'b0;
            ipl_q       <= 3'b111;
            ack_lvl_q   <= 3'd0;
            valid_q     <= 1'b0;
            cnt_q       <= '0;
            int_ack_q   <= 7'd0;
            iack_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            req7_prev_q <= req7_prev_d;
            nmi_pend_q  <= nmi_pend_d;
            ipl_q       <= ipl_d;
            ack_lvl_q   <= ack_lvl_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            int_ack_q   <= int_ack_d;
            iack_err_q  <= iack_err_d;
        end
    end

    assign vector   = valid_q ? (VEC_BASE + {5'd0, ack_lvl_q}) : VEC_BASE;
    assign vpa      = (state_q == RESP);
    assign data_out = vpa ? {8'h00, vector} : 16'h0000;
    assign _ipl     = ipl_q;
    assign int_ack  = int_ack_q;
    assign iack_err = iack_err_q;

endmodule

// File: doc/ipl_iack_responder.md
# ipl_iack_responder

Interrupt-side counterpart to the cartridge/peripheral interrupt requesters (the Action Replay INT7 source, Paula levels 1-6). It merges the level requests into the 68000 `_IPL` encoding and detects CPU interrupt-acknowledge cycles. It answers each acknowledge with an autovector response and returns a one-cycle acknowledge pulse to the source that was serviced. It sits between the request sources and the CPU bus glue, and its `data_out` is OR-ed onto the CPU read bus.

## Interface
- `TIMEOUT`, default 64: clk cycles allowed in RESP before the acknowledge is abandoned.
- `VEC_BASE`, default 8'h18: autovector base; vector = `VEC_BASE + level`.
- `clk`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-low.
- `int_req`, in, [7:1]: interrupt requests. Bits 6:1 are level-sensitive. Bit 7 is rising-edge (NMI).
- `cpu_address`, in, [23:1]: CPU address bus.
- `_cpu_as`, in, 1: CPU address strobe, active-low.
- `cpu_rd`, in, 1: CPU read cycle.
- `_ipl`, out, [2:0]: encoded priority level, active-low (3'b111 = none).
- `vpa`, out, 1: autovector response asserted during acknowledge.
- `data_out`, out, [15:0]: `{8'h00, vector}` while in RESP, else 16'h0000.
- `int_ack`, out, [7:1]: one-cycle pulse on the serviced level.
- `iack_err`, out, 1: one-cycle pulse on a spurious acknowledge or a timeout.

## Operation
- **Request sampling:** `int_req` is registered once into `req_q`.
- **Level 7 latch:** `nmi_pend` is set on a rising edge of `req_q[7]`. It is cleared by `int_ack[7]`. If set and clear occur in the same cycle, set wins.
- **Pending vector:** pending = `{nmi_pend, req_q[6:1]}`. The highest set bit gives `lvl_enc` (0 = none).
- **Priority output:** `_ipl <= ~lvl_enc` every cycle while in IDLE. `_ipl` is frozen in RESP and WAIT so the CPU sees a stable level through the acknowledge.
- **IACK hit:** `&cpu_address[23:4] & ~_cpu_as & cpu_rd & (cpu_address[3:1]!=0)`. Address level 0 is never a hit.
- **FSM states:**
  - IDLE: on an IACK hit, capture `ack_lvl = cpu_address[3:1]` and `valid = pending[ack_lvl]`, clear the timeout counter, go to RESP.
  - RESP: drive `vpa=1` and `data_out = valid ? VEC_BASE+ack_lvl : VEC_BASE`; the spurious case uses vector 24.
    - On `_cpu_as` high: if `valid`, pulse `int_ack[ack_lvl]`, else pulse `iack_err`. Then go to IDLE.
    - If the counter reaches `TIMEOUT-1` with `_cpu_as` still low: pulse `iack_err`, drop `vpa`, go to WAIT. No `int_ack` is issued.
  - WAIT: outputs idle. Go to IDLE once `_cpu_as` is high. This prevents a re-hit on the same strobe.
- **Request drops mid-acknowledge:** the captured `valid` still holds. The acknowledge is completed, and `int_ack` is pulsed harmlessly.
- **Reset (reset==0) values:** state=IDLE, `_ipl`=3'b111, `vpa`=0, `data_out`=0, `int_ack`=0, `iack_err`=0, `nmi_pend`=0, `req_q`=0. Reset mid-acknowledge aborts with no pulses.

## Timing
- `int_req` to `_ipl`: 2 clk (sample register, then `_ipl` register), provided the FSM is in IDLE.
- IACK hit to `vpa`/`data_out` valid: 1 clk (registered). Both stay valid until the cycle after `_cpu_as` is seen high.
- `_cpu_as` high to `int_ack` pulse: 1 clk. The pulse is exactly 1 clk wide.
- `nmi_pend` clears in the cycle after the `int_ack[7]` pulse, so `_ipl` can leave level 7 2 clk after the `int_ack[7]` pulse.
- Timeout: `iack_err` pulses `TIMEOUT` clk after entry to RESP.
- Back-to-back acknowledges: a new hit is accepted in the first IDLE cycle.

## Structure
- Shared package `ipl_pkg`:
  - state enum {IDLE, RESP, WAIT};
  - `VEC_SPURIOUS` = 8'h18;
  - IACK address-mask constant;
  - `lvl_t` (3-bit level type).
- Sub-module `ipl_prio_enc`: combinational 7-to-3 priority encoder, pending vector to `lvl_enc`. It is reused by the Paula interrupt logic.
- Timeout counter width: `$clog2(TIMEOUT)`. It saturates, it does not wrap.

## Test plan
- **Level request:** `int_req`=7'b0000100 (level 3) → `_ipl`=3'b100 after 2 clk. Then an IACK at address 24'hFFFFF6 (A[3:1]=3) → `vpa`=1, `data_out`=16'h001B. On `_cpu_as` rise, `int_ack`=7'b0000100 for 1 clk.
- **Priority:** levels 2 and 5 both requested → `_ipl`=3'b010. Drop level 5 → `_ipl`=3'b101 after 2 clk.
- **NMI edge latch:** 1-clk pulse on `int_req[7]` → `_ipl`=3'b000 held. IACK level 7 → `data_out`=16'h001F, `int_ack[7]` pulses, `_ipl` returns to 3'b111. A new edge in the ack cycle keeps `_ipl`=3'b000.
- **Spurious:** no requests, IACK at level 4 → `data_out`=16'h0018, `iack_err` pulses, `int_ack`=0.
- **Timeout:** `_cpu_as` held low 100 clk (`TIMEOUT`=64) → `iack_err` at clk 64, `vpa` drops, no re-hit until `_cpu_as` goes high.
- **Reset mid-acknowledge:** `reset`=0 during RESP → next clk `vpa`=0, `_ipl`=3'b111, no `int_ack`.
